ccu_lat_slice: RTL
==================

CCU_LAT_SLICE -- requirements
Module: ccu_lat_slice

Interface
REQ-001 SHALL have parameter NumChan, default 10, number of independent channels; one mode bit per channel, bit order matching the CCU latency mask (bit 9 = Demux AW ... bit 0 = Mux R).
REQ-002 SHALL have parameter DataWidth, default 64, payload width per channel.
REQ-003 SHALL have parameter Depth, default 2, buffer slots per channel in cut mode; legal range 1..16.
REQ-004 SHALL have parameter ResetMode, default all-zero, NumChan-bit active cut mask loaded at reset.
REQ-005 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port lat_mode_i, input, NumChan, requested cut mask (1 = registered, 0 = bypass).
REQ-008 SHALL have ports slv_valid_i (input, NumChan), slv_ready_o (output, NumChan) and slv_data_i (input, NumChan*DataWidth); these form the upstream handshake per channel.
REQ-009 SHALL have ports mst_valid_o (output, NumChan), mst_ready_i (input, NumChan) and mst_data_o (output, NumChan*DataWidth); these form the downstream handshake per channel.
REQ-010 SHALL have port mode_pending_o, output, NumChan, meaning requested mode differs from active mode.
REQ-011 SHALL have port active_mode_o, output, NumChan, the current active cut mask.

Function
REQ-012 SHALL treat each channel independently; no cross-channel combinational or state dependency.
REQ-013 SHALL, in bypass (active bit 0), connect mst_valid_o = slv_valid_i, slv_ready_o = mst_ready_i and mst_data_o = slv_data_i combinationally, with zero latency.
REQ-014 SHALL, in cut mode (active bit 1), implement a Depth-entry FIFO: push on slv_valid_i & slv_ready_o; pop on mst_valid_o & mst_ready_i.
REQ-015 SHALL, in cut mode, drive slv_ready_o = !full and mst_valid_o = !empty, with no combinational path from mst_ready_i to slv_ready_o.
REQ-016 SHALL give a 1-cycle minimum latency in cut mode: a word pushed in cycle N is visible on mst_valid_o/mst_data_o in cycle N+1.
REQ-017 SHALL, in cut mode with the FIFO neither full nor empty, allow simultaneous push and pop in one cycle with occupancy unchanged.
REQ-018 SHALL keep occupancy in a $clog2(Depth+1)-bit counter; read/write pointers wrap from Depth-1 to 0 (Depth need not be a power of two).
REQ-019 SHALL deliver data in-order and loss-free; mst_data_o stays stable while mst_valid_o=1 and mst_ready_i=0.
REQ-020 SHALL run a per-channel mode FSM with states ACTIVE, DRAIN and SWITCH.
REQ-021 SHALL transition the mode FSM from ACTIVE to DRAIN when lat_mode_i bit differs from the active bit.
REQ-022 SHALL, in DRAIN, hold slv_ready_o=0 and continue popping; in bypass-active channels DRAIN completes in one cycle with slv_ready_o forced 0.
REQ-023 SHALL transition the mode FSM from DRAIN to SWITCH when occupancy=0, and from SWITCH to ACTIVE in the following cycle while updating the active bit.
REQ-024 SHALL, if lat_mode_i returns to the active value during DRAIN, go back to ACTIVE without switching.
REQ-025 SHALL set mode_pending_o=1 while the mode FSM is in DRAIN or SWITCH.
REQ-026 SHALL hold slv_ready_o=0 and mst_valid_o=0 in SWITCH.
REQ-027 SHALL not create or drop a transfer across a mode change; any held upstream word is accepted after the switch.

Reset
REQ-028 SHALL, while rst_i=1, force slv_ready_o=0, mst_valid_o=0 and mode_pending_o=0 on all channels, regardless of mode.
REQ-029 SHALL, on reset, clear every FIFO (occupancy 0, pointers 0), set the active mask to ResetMode and every mode FSM to ACTIVE.
REQ-030 SHALL, on reset mid-transfer or mid-drain, discard buffered data; the first cycle after rst_i falls follows ResetMode.
REQ-031 SHALL reset mst_data_o to 0 in cut mode.

Verification
REQ-032 SHALL cover bypass: mode 0, slv_valid_i=1 with data 0xA5, mst_ready_i=1 -> mst_valid_o=1 and mst_data_o=0xA5 in the same cycle.
REQ-033 SHALL cover cut fill with Depth=2 and mst_ready_i=0: push 0x1 then 0x2 -> slv_ready_o=0 after the second push; release ready -> 0x1 then 0x2 in order, and slv_ready_o returns 1 the cycle after the first pop.
REQ-034 SHALL cover streaming: Depth=2, continuous valid/ready -> one word per cycle, latency exactly 1, no bubbles.
REQ-035 SHALL cover switch cut->bypass: 2 entries buffered, lat_mode_i bit -> 0 -> mode_pending_o=1, slv_ready_o=0, 2 pops, then SWITCH for 1 cycle, then bypass with mode_pending_o=0.
REQ-036 SHALL cover aborted switch: lat_mode_i toggles and returns within DRAIN -> active bit unchanged, no data lost.
REQ-037 SHALL cover reset mid-stream: rst_i asserted with 1 entry buffered -> next cycle mst_valid_o=0 and occupancy 0; active_mode_o equals ResetMode.

Source files
------------

// File: rtl/ccu_lat_slice.sv
`default_nettype none
// ============================================================================
//  Module   : ccu_lat_slice
//  Purpose  : Per-channel latency slice. Each channel is either a zero-latency
//             combinational bypass or a Depth-entry FIFO cut. A small mode FSM
//             drains the FIFO before the active mode changes, so no transfer
//             is ever created or lost.
//  Revision : 1.0 - initial release
// ============================================================================
module ccu_lat_slice #(
   parameter int                  NumChan   = 10,
   parameter int                  DataWidth = 64,
   parameter int                  Depth     = 2,
   parameter logic [NumChan-1:0]  ResetMode = '0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumChan-1:0]             lat_mode_i,
   input  logic [NumChan-1:0]             slv_valid_i,
   output logic [NumChan-1:0]             slv_ready_o,
   input  logic [NumChan*DataWidth-1:0]   slv_data_i,
   output logic [NumChan-1:0]             mst_valid_o,
   input  logic [NumChan-1:0]             mst_ready_i,
   output logic [NumChan*DataWidth-1:0]   mst_data_o,
   output logic [NumChan-1:0]             mode_pending_o,
   output logic [NumChan-1:0]             active_mode_o
);

   // Pointers need at least one bit even when Depth is 1.
   localparam int PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CNT_W = $clog2(Depth + 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   for (genvar ch = 0; ch < NumChan; ch++) begin : g_chan
      state_t                 state;
      state_t                 state_next;
      logic                   active;
      logic                   want;
      logic [DataWidth-1:0]   mem [Depth];
      logic [PTR_W-1:0]       wptr;
      logic [PTR_W-1:0]       rptr;
      logic [CNT_W-1:0]       count;
      logic [DataWidth-1:0]   in_data;
      logic [DataWidth-1:0]   out_data;
      logic                   full;
      logic                   empty;
      logic                   ready;
      logic                   valid;
      logic                   push;
      logic                   pop;

      assign in_data = slv_data_i[ch*DataWidth +: DataWidth];
      assign want    = lat_mode_i[ch];
      assign full    = (count == CNT_W'(Depth));
      assign empty   = (count == '0);

      // Handshake steering and next mode-FSM state.
      always_comb begin
         ready      = 1'b0;
         valid      = 1'b0;
         state_next = state;
         // Cut mode shows zero while empty so the output is 0 out of reset.
         if (active) out_data = empty ? '0 : mem[rptr];
         else        out_data = in_data;
         case (state)
            ST_ACTIVE: begin
               if (active) begin
                  ready = !full;
                  valid = !empty;
               end else begin
                  ready = mst_ready_i[ch];
                  valid = slv_valid_i[ch];
               end
               if (want != active) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
               // Upstream is stalled; a bypass channel has nothing to drain and
               // must not forward a word it is refusing upstream.
               valid = active & !empty;
               if (want == active) state_next = ST_ACTIVE;
               else if (empty)     state_next = ST_SWITCH;
            end
            ST_SWITCH: begin
               state_next = ST_ACTIVE;
            end
            default: begin
               state_next = ST_ACTIVE;
            end
         endcase
         if (rst_i) begin
            ready = 1'b0;
            valid = 1'b0;
         end
      end

      assign push = active & slv_valid_i[ch] & ready;
      assign pop  = active & valid & mst_ready_i[ch];

      // Mode FSM, active bit, FIFO pointers and occupancy.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state  <= ST_ACTIVE;
            active <= ResetMode[ch];
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
         end else begin
            state <= state_next;
            if (state == ST_SWITCH) active <= want;
            if (push) wptr <= (wptr == PTR_W'(Depth - 1)) ? '0 : wptr + PTR_W'(1);
            if (pop)  rptr <= (rptr == PTR_W'(Depth - 1)) ? '0 : rptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end

      // Payload storage; contents are only observed while occupancy is non-zero.
      always_ff @(posedge clk_i) begin
         if (push) mem[wptr] <= in_data;
      end

      assign slv_ready_o[ch]                        = ready;
      assign mst_valid_o[ch]                        = valid;
      assign mst_data_o[ch*DataWidth +: DataWidth]  = out_data;
      assign active_mode_o[ch]                      = active;
      assign mode_pending_o[ch]                     = !rst_i &
                                                      ((state != ST_ACTIVE) | (want != active));
   end

endmodule
`default_nettype wire
